iiitb_cg_ctrl: RTL

//  Clock-gate enable controller, directly upstream of the integrated clock-gating cell.

---
 rtl/iiitb_cg_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/iiitb_cg_ctrl.sv
// Clock-gate enable controller: drops cg_en after a run of idle cycles and restores it,
// with a settle period, when traffic or force_on reappears.
module iiitb_cg_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] d_in,
    input  logic       force_on,
    output logic       cg_en,
    output logic [1:0] d_out,
    output logic       d_out_valid,
    output logic       sleeping,
    output logic [7:0] wake_count
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] wake_cnt;
    logic             accept;

    // cg_en and sleeping are registered from the next state so the gating latch sees a clean level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACTIVE;
            idle_cnt    <= '0;
            wake_cnt    <= '0;
            cg_en       <= 1'b1;
            d_out       <= 2'b00;
            d_out_valid <= 1'b0;
            sleeping    <= 1'b0;
            wake_count  <= 8'h00;
        end else begin
            state       <= state_nxt;
            cg_en       <= (state_nxt != SLEEP);
            sleeping    <= (state_nxt == SLEEP);
            d_out_valid <= accept;
            if (accept) begin
                d_out <= d_in;
            end
            case (state)
                ACTIVE: begin
                    // cleared on SLEEP entry too, so the counter never reaches IDLE_CYCLES
                    if (accept || force_on || state_nxt == SLEEP) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                SLEEP: begin
                    if (state_nxt == WAKE) begin
                        wake_cnt <= '0;
                        if (wake_count != 8'hFF) begin
                            wake_count <= wake_count + 8'd1;
                        end
                    end
                end
                WAKE: begin
                    wake_cnt <= wake_cnt + 1'b1;
                    if (state_nxt == ACTIVE) begin
                        idle_cnt <= '0;
                    end
                end
                default: begin
                    idle_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACTIVE: begin
                // an accept on the terminal idle cycle keeps the clock running
                if (!accept && !force_on && idle_cnt == IDLE_LAST) begin
                    state_nxt = SLEEP;
                end
            end
            SLEEP: begin
                if (in_valid || force_on) begin
                    state_nxt = WAKE;
                end
            end
            WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = ACTIVE;
                end
            end
            default: begin
                state_nxt = ACTIVE;
            end
        endcase
    end

    always_comb begin
        in_ready = (state == ACTIVE);
        accept   = in_valid && in_ready;
    end

endmodule
